// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Contents: RV64 opcode and funct constants for the supported integer subset,
// the 3-bit ALU operation encoding understood by the datapath, the control FSM
// state type and a helper that maps funct3 onto an ALU operation.
package cpu_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values (R-type) and funct6 for RV64 immediate shifts
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [5:0] F6_SHIFT   = 6'b000000;

    // ALU operation encoding
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control FSM states
    typedef logic [2:0] state_t;
    localparam state_t StIdle      = 3'd0;
    localparam state_t StDecode    = 3'd1;
    localparam state_t StExecute   = 3'd2;
    localparam state_t StMem       = 3'd3;
    localparam state_t StWriteback = 3'd4;

    // alt selects SUB for funct3 000; it is ignored for every other funct3.
    function automatic logic [2:0] alu_from_f3(input logic [2:0] funct3, input logic alt);
        logic [2:0] op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_XOR:     op = ALU_XOR;
            F3_SRL:     op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one 32-bit RV64 instruction into datapath control fields.
// Ports:
//   instr_i    : instruction word
//   rs1_o/rs2_o/rd_o : register addresses (rs2 only for R-type and sd, rd 0 for sd)
//   imm_o      : raw 12-bit immediate (I-type/ld layout or S-type layout)
//   b_imm_o    : ALU B operand comes from the immediate
//   wb_mem_o   : writeback value comes from data memory (ld)
//   alu_op_o   : ALU operation
//   is_load_o/is_store_o : memory access class
//   legal_o    : encoding belongs to the supported subset
// All field outputs are forced to zero for an illegal encoding.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [11:0] imm_o,
    output logic        b_imm_o,
    output logic        wb_mem_o,
    output logic [2:0]  alu_op_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        legal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        rs1_o      = '0;
        rs2_o      = '0;
        rd_o       = '0;
        imm_o      = '0;
        b_imm_o    = 1'b0;
        wb_mem_o   = 1'b0;
        alu_op_o   = ALU_ADD;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        legal_o    = 1'b0;

        case (opcode)
            OPC_OP: begin
                // Base funct7 covers everything but sltu; the alternate funct7 is only sub.
                legal_o  = ((funct7 == F7_BASE) && (funct3 != F3_DWORD)) ||
                           ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB));
                rs1_o    = instr_i[19:15];
                rs2_o    = instr_i[24:20];
                rd_o     = instr_i[11:7];
                alu_op_o = alu_from_f3(funct3, funct7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                case (funct3)
                    // RV64 shifts carry a 6-bit shamt, so only funct6 qualifies them
                    F3_SLL, F3_SRL: legal_o = (instr_i[31:26] == F6_SHIFT);
                    F3_DWORD:       legal_o = 1'b0;
                    default:        legal_o = 1'b1;
                endcase
                rs1_o    = instr_i[19:15];
                rd_o     = instr_i[11:7];
                imm_o    = instr_i[31:20];
                b_imm_o  = 1'b1;
                alu_op_o = alu_from_f3(funct3, 1'b0);
            end
            OPC_LOAD: begin
                legal_o   = (funct3 == F3_DWORD);
                rs1_o     = instr_i[19:15];
                rd_o      = instr_i[11:7];
                imm_o     = instr_i[31:20];
                b_imm_o   = 1'b1;
                wb_mem_o  = 1'b1;
                is_load_o = 1'b1;
            end
            OPC_STORE: begin
                legal_o    = (funct3 == F3_DWORD);
                rs1_o      = instr_i[19:15];
                rs2_o      = instr_i[24:20];
                imm_o      = {instr_i[31:25], instr_i[11:7]};
                b_imm_o    = 1'b1;
                is_store_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase

        if (!legal_o) begin
            rs1_o      = '0;
            rs2_o      = '0;
            rd_o       = '0;
            imm_o      = '0;
            b_imm_o    = 1'b0;
            wb_mem_o   = 1'b0;
            alu_op_o   = ALU_ADD;
            is_load_o  = 1'b0;
            is_store_o = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit sequencing the register file / ALU / data memory datapath.
// Accepts one instruction per valid/ready handshake (only while idle), then walks
// DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] and pulses done on retirement.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   instr, instr_valid    : instruction offer; instr_ready high only when idle
//   rf_addr_a/b, rf_write_addr, rf_write_en : register file control
//   immediate, mux_0_sel, mux_1_sel, mux_2_sel, alu_operation : datapath selects
//   dm_write_en           : data memory write strobe
//   done, illegal_instr   : one-cycle retire / unsupported-encoding pulses
//   retired_count         : wrapping count of retired legal instructions
// Every output is a flop. Outputs are computed from the next state, so a signal
// that "belongs" to a state is high exactly while the FSM sits in that state.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       rf_addr_a,
    output logic [4:0]       rf_addr_b,
    output logic [4:0]       rf_write_addr,
    output logic             rf_write_en,
    output logic [11:0]      immediate,
    output logic             mux_0_sel,
    output logic             mux_1_sel,
    output logic             mux_2_sel,
    output logic [2:0]       alu_operation,
    output logic             dm_write_en,
    output logic             done,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired_count
);

    if (CNT_W > WORDSIZE) begin : g_cnt_w_check
        $error("CNT_W must not exceed WORDSIZE");
    end

    // Decoder outputs
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [11:0] dec_imm;
    logic        dec_b_imm, dec_wb_mem, dec_is_load, dec_is_store, dec_legal;
    logic [2:0]  dec_alu_op;

    instr_decoder u_instr_decoder (
        .instr_i    (instr),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .imm_o      (dec_imm),
        .b_imm_o    (dec_b_imm),
        .wb_mem_o   (dec_wb_mem),
        .alu_op_o   (dec_alu_op),
        .is_load_o  (dec_is_load),
        .is_store_o (dec_is_store),
        .legal_o    (dec_legal)
    );

    state_t             state_q, state_d;
    logic               ready_q, illegal_q, done_q, rf_we_q, dm_we_q;
    logic [4:0]         rs1_q, rs2_q, rd_q;
    logic [11:0]        imm_q;
    logic               b_imm_q, wb_mem_q, is_load_q, is_store_q;
    logic [2:0]         alu_op_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               retire_d;

    assign accept = (state_q == StIdle) && instr_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (accept) state_d = StDecode;
            // illegal_q was captured at the handshake and is only high during DECODE
            StDecode:    state_d = illegal_q ? StIdle : StExecute;
            StExecute:   state_d = (is_load_q || is_store_q) ? StMem : StWriteback;
            StMem:       state_d = is_load_q ? StWriteback : StIdle;
            StWriteback: state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    assign retire_d = (state_d == StWriteback) || ((state_d == StMem) && is_store_q);
    assign cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, retire_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            cnt_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            b_imm_q    <= 1'b0;
            wb_mem_q   <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            alu_op_q   <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == StIdle);
            illegal_q <= accept && !dec_legal;
            done_q    <= retire_d;
            rf_we_q   <= (state_d == StWriteback) && (rd_q != 5'd0);
            dm_we_q   <= (state_d == StMem) && is_store_q;
            cnt_q     <= cnt_d;
            // Fields are captured once per instruction and hold until the next handshake.
            if (accept) begin
                rs1_q      <= dec_rs1;
                rs2_q      <= dec_rs2;
                rd_q       <= dec_rd;
                imm_q      <= dec_imm;
                b_imm_q    <= dec_b_imm;
                wb_mem_q   <= dec_wb_mem;
                is_load_q  <= dec_is_load;
                is_store_q <= dec_is_store;
                alu_op_q   <= dec_alu_op;
            end
        end
    end

    assign instr_ready   = ready_q;
    assign rf_addr_a     = rs1_q;
    assign rf_addr_b     = rs2_q;
    assign rf_write_addr = rd_q;
    assign rf_write_en   = rf_we_q;
    assign immediate     = imm_q;
    assign mux_0_sel     = b_imm_q;
    assign mux_1_sel     = wb_mem_q;
    assign mux_2_sel     = 1'b0;
    assign alu_operation = alu_op_q;
    assign dm_write_en   = dm_we_q;
    assign done          = done_q;
    assign illegal_instr = illegal_q;
    assign retired_count = cnt_q;

endmodule
